// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// mux_scan : registered N-channel mux, manual select or auto-scan with dwell.
//            Optional channel mask enabled by defining MUX_SCAN_CH_MASK_EN.
// Revision : 1.0  initial release
// ============================================================================
module mux_scan #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 pause,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in,
`ifdef MUX_SCAN_CH_MASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]     out,
  output logic [SELW-1:0]      cur_ch,
  output logic                 wrap,
  output logic                 err
);

  localparam int              C_CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [C_CNTW-1:0] C_LAST = C_CNTW'(DWELL - 1);

  typedef enum logic [0:0] {
    S_MANUAL = 1'b0,
    S_SCAN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [SELW-1:0]     cur_ch_q, cur_ch_d;
  logic [C_CNTW-1:0]   cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;

  logic [NCH-1:0]      ch_en;
  logic                any_en;
  logic                sel_valid;
  logic [WIDTH-1:0]    sel_data;
  logic [WIDTH-1:0]    cur_data;
  logic                nxt_found;
  logic [SELW-1:0]     nxt_idx;
  int                  j;

`ifdef MUX_SCAN_CH_MASK_EN
  assign ch_en = ch_mask;
`else
  assign ch_en = '1;
`endif

  assign any_en = |ch_en;

  // A select is valid only if it names an existing, enabled channel.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    cur_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        sel_valid = ch_en[k];
        sel_data  = in[k*WIDTH +: WIDTH];
      end
      if (cur_ch_q == SELW'(k)) begin
        cur_data = in[k*WIDTH +: WIDTH];
      end
    end
  end

  // First enabled channel after cur_ch, searching modulo NCH.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = cur_ch_q;
    j         = 0;
    for (int i = 1; i <= NCH; i++) begin
      j = int'(cur_ch_q) + i;
      if (j >= NCH) begin
        j = j - NCH;
      end
      for (int k = 0; k < NCH; k++) begin
        if (!nxt_found && (j == k) && ch_en[k]) begin
          nxt_found = 1'b1;
          nxt_idx   = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    state_d  = mode ? S_SCAN : S_MANUAL;
    out_d    = out_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    if (!mode) begin
      cnt_d = '0;
      if (sel_valid) begin
        cur_ch_d = sel;
        out_d    = sel_data;
      end else begin
        err_d = 1'b1;
      end
    end else if (any_en) begin
      out_d = cur_data;
      if (state_q == S_MANUAL) begin
        cnt_d = '0;
      end else if (!pause) begin
        if (cnt_q == C_LAST) begin
          cnt_d    = '0;
          cur_ch_d = nxt_idx;
          wrap_d   = (nxt_idx < cur_ch_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_MANUAL;
      out_q    <= '0;
      cur_ch_q <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign out    = out_q;
  assign cur_ch = cur_ch_q;
  assign wrap   = wrap_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// tb_mux_scan : vector table, directed scan/pause/collision/reset sequences and
//               randomized traffic against a behavioural channel-sampler model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode_a, pause_a;
  logic [1:0]  sel_a;
  logic [3:0]  in_a;
  logic [3:0]  mask_a = 4'hF;
  logic [0:0]  out_a;
  logic [1:0]  cur_a;
  logic        wrap_a, err_a;

  logic        mode_b, pause_b;
  logic [1:0]  sel_b;
  logic [11:0] in_b;
  logic [2:0]  mask_b = 3'h7;
  logic [3:0]  out_b;
  logic [1:0]  cur_b;
  logic        wrap_b, err_b;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(1), .NCH(4), .SELW(2), .DWELL(4)) u_dut_a (
    .clk(clk), .rst(rst), .mode(mode_a), .pause(pause_a), .sel(sel_a), .in(in_a),
`ifdef MUX_SCAN_CH_MASK_EN
    .ch_mask(mask_a),
`endif
    .out(out_a), .cur_ch(cur_a), .wrap(wrap_a), .err(err_a)
  );

  mux_scan #(.WIDTH(4), .NCH(3), .SELW(2), .DWELL(1)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .pause(pause_b), .sel(sel_b), .in(in_b),
`ifdef MUX_SCAN_CH_MASK_EN
    .ch_mask(mask_b),
`endif
    .out(out_b), .cur_ch(cur_b), .wrap(wrap_b), .err(err_b)
  );

  typedef struct {
    logic       pause;
    logic [1:0] sel;
    logic [3:0] in_a;
    logic [11:0] in_b;
    logic       ea_out;
    logic [1:0] ea_cur;
    logic [3:0] eb_out;
    logic [1:0] eb_cur;
    logic       eb_err;
  } vec_t;

  typedef struct {
    bit scanning;
    int ch;
    int cnt;
    int out;
    bit wrap;
    bit err;
  } model_t;

  vec_t   tbl [7];
  model_t ma, mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int chan(input logic [63:0] inv, input int k, input int width);
    logic [63:0] v;
    v = (inv >> (k * width)) & ((64'd1 << width) - 64'd1);
    return int'(v);
  endfunction

  // One clock of the sampler described at channel level: index arithmetic modulo nch.
  function automatic model_t model_step(input model_t m, input logic md, input logic ps,
                                        input int sel, input logic [63:0] inv, input int nch,
                                        input int dwell, input int width, input logic [15:0] en);
    model_t n;
    bit     any;
    int     nx;
    n      = m;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    any    = 1'b0;
    for (int k = 0; k < nch; k++) any |= en[k];
    if (!md) begin
      n.scanning = 1'b0;
      n.cnt      = 0;
      if (sel < nch && en[sel]) begin
        n.ch  = sel;
        n.out = chan(inv, sel, width);
      end else begin
        n.err = 1'b1;
      end
    end else begin
      n.scanning = 1'b1;
      if (any) begin
        n.out = chan(inv, m.ch, width);
        if (!m.scanning) begin
          n.cnt = 0;
        end else if (!ps) begin
          if (m.cnt + 1 == dwell) begin
            nx = m.ch;
            for (int i = nch; i >= 1; i--) begin
              if (en[(m.ch + i) % nch]) nx = (m.ch + i) % nch;
            end
            n.cnt  = 0;
            n.ch   = nx;
            n.wrap = (nx < m.ch);
          end else begin
            n.cnt = m.cnt + 1;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic do_reset();
    mode_a = 1'b0; pause_a = 1'b0; sel_a = 2'd0;
    mode_b = 1'b0; pause_b = 1'b0; sel_b = 2'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ma = '{scanning: 1'b0, ch: 0, cnt: 0, out: 0, wrap: 1'b0, err: 1'b0};
    mb = '{scanning: 1'b0, ch: 0, cnt: 0, out: 0, wrap: 1'b0, err: 1'b0};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int pc, ec;
    logic exp_hold;

    tbl[0] = '{1'b0, 2'd1, 4'b1010, 12'hC95, 1'b1, 2'd1, 4'h9, 2'd1, 1'b0};
    tbl[1] = '{1'b0, 2'd2, 4'b1010, 12'hC95, 1'b0, 2'd2, 4'hC, 2'd2, 1'b0};
    tbl[2] = '{1'b0, 2'd3, 4'b1010, 12'hC95, 1'b1, 2'd3, 4'hC, 2'd2, 1'b1};
    tbl[3] = '{1'b0, 2'd0, 4'b0101, 12'h3A7, 1'b1, 2'd0, 4'h7, 2'd0, 1'b0};
    tbl[4] = '{1'b0, 2'd3, 4'b0101, 12'h3A7, 1'b0, 2'd3, 4'h7, 2'd0, 1'b1};
    tbl[5] = '{1'b0, 2'd3, 4'b0101, 12'h3A7, 1'b0, 2'd3, 4'h7, 2'd0, 1'b1};
    tbl[6] = '{1'b1, 2'd1, 4'b0101, 12'h3A7, 1'b0, 2'd1, 4'hA, 2'd1, 1'b0};

    // Reset held until 20 ns with inputs that would otherwise load nonzero data.
    rst = 1'b1;
    mode_a = 1'b0; pause_a = 1'b0; sel_a = 2'd1; in_a = 4'b1010;
    mode_b = 1'b0; pause_b = 1'b0; sel_b = 2'd1; in_b = 12'hC95;
    #12;
    check("rst_a_out", out_a, 0);  check("rst_a_cur", cur_a, 0);
    check("rst_a_wrap", wrap_a, 0); check("rst_a_err", err_a, 0);
    check("rst_b_out", out_b, 0);  check("rst_b_cur", cur_b, 0);
    check("rst_b_wrap", wrap_b, 0); check("rst_b_err", err_b, 0);
    #8;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      sel_a = tbl[i].sel;  sel_b = tbl[i].sel;
      pause_a = tbl[i].pause; pause_b = tbl[i].pause;
      in_a = tbl[i].in_a;  in_b = tbl[i].in_b;
      step();
      check($sformatf("tbl%0d_a_out", i), out_a, tbl[i].ea_out);
      check($sformatf("tbl%0d_a_cur", i), cur_a, tbl[i].ea_cur);
      check($sformatf("tbl%0d_a_err", i), err_a, 0);
      check($sformatf("tbl%0d_a_wrap", i), wrap_a, 0);
      check($sformatf("tbl%0d_b_out", i), out_b, tbl[i].eb_out);
      check($sformatf("tbl%0d_b_cur", i), cur_b, tbl[i].eb_cur);
      check($sformatf("tbl%0d_b_err", i), err_b, tbl[i].eb_err);
      check($sformatf("tbl%0d_b_wrap", i), wrap_b, 0);
    end
    pause_a = 1'b0; pause_b = 1'b0;

    // Scan from channel 0: dwell 4, wrap once at t = 16.
    sel_a = 2'd0; sel_b = 2'd0;
    step();
    mode_a = 1'b1;
    pc = 0;
    for (int t = 0; t <= 18; t++) begin
      in_a = 4'($urandom);
      step();
      ec = (t / 4) % 4;
      check($sformatf("scan%0d_cur", t), cur_a, ec);
      check($sformatf("scan%0d_out", t), out_a, in_a[pc]);
      check($sformatf("scan%0d_wrap", t), wrap_a, (t > 0 && t % 4 == 0 && ec == 0));
      pc = ec;
    end

    // Count is 2 here; hold for five cycles, then two more edges to the advance.
    pause_a = 1'b1;
    for (int t = 0; t < 5; t++) begin
      in_a = 4'($urandom);
      step();
      check($sformatf("pause%0d_cur", t), cur_a, 0);
      check($sformatf("pause%0d_out", t), out_a, in_a[0]);
      check($sformatf("pause%0d_wrap", t), wrap_a, 0);
    end
    pause_a = 1'b0;
    step();
    check("resume1_cur", cur_a, 0);
    check("resume1_wrap", wrap_a, 0);
    in_a = 4'($urandom);
    step();
    check("resume2_cur", cur_a, 1);
    check("resume2_out", out_a, in_a[0]);
    check("resume2_wrap", wrap_a, 0);

    for (int t = 0; t < 11; t++) begin
      in_a = 4'($urandom);
      step();
    end
    check("pre_collide_cur", cur_a, 3);

    // Leave scan exactly on the expiry edge of the last channel.
    mode_a = 1'b0; sel_a = 2'd3; in_a = 4'($urandom);
    step();
    check("collide_cur", cur_a, 3);
    check("collide_out", out_a, in_a[3]);
    check("collide_wrap", wrap_a, 0);
    check("collide_err", err_a, 0);
    sel_a = 2'd2; in_a = 4'($urandom);
    step();
    check("post_collide_cur", cur_a, 2);
    check("post_collide_out", out_a, in_a[2]);

    // Asynchronous reset in the middle of a dwell on channel 2.
    mode_a = 1'b1; in_a = 4'hF;
    step();
    step();
    check("prerst_out", out_a, 1);
    check("prerst_cur", cur_a, 2);
    #3;
    rst = 1'b1;
    #1;
    check("asyncrst_out", out_a, 0);
    check("asyncrst_cur", cur_a, 0);
    check("asyncrst_wrap", wrap_a, 0);
    check("asyncrst_err", err_a, 0);
    step();
    check("heldrst_out", out_a, 0);
    rst = 1'b0;

`ifdef MUX_SCAN_CH_MASK_EN
    do_reset();
    mask_a = 4'b0101;
    step();
    mode_a = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      in_a = 4'($urandom);
      step();
      check($sformatf("mask%0d_cur", t), cur_a, ((t / 4) % 2) * 2);
      check($sformatf("mask%0d_wrap", t), wrap_a, (t > 0 && t % 8 == 0));
      exp_hold = in_a[2];
    end
    mask_a = 4'b0000;
    for (int t = 0; t < 5; t++) begin
      in_a = 4'($urandom);
      step();
      check($sformatf("allmask%0d_cur", t), cur_a, 0);
      check($sformatf("allmask%0d_out", t), out_a, exp_hold);
    end
    mask_a = 4'b0101; mode_a = 1'b0; sel_a = 2'd1;
    step();
    check("masksel_err", err_a, 1);
    check("masksel_cur", cur_a, 0);
    mask_a = 4'hF;
`else
    exp_hold = 1'b0;
`endif

    do_reset();
    mode_a = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 15) == 0) mode_b = ~mode_b;
      pause_a = ($urandom_range(0, 3) == 0);
      pause_b = ($urandom_range(0, 3) == 0);
      sel_a = 2'($urandom);  sel_b = 2'($urandom);
      in_a  = 4'($urandom);  in_b  = 12'($urandom);
`ifdef MUX_SCAN_CH_MASK_EN
      if ($urandom_range(0, 31) == 0) mask_a = 4'($urandom);
      if ($urandom_range(0, 31) == 0) mask_b = 3'($urandom);
`endif
      step();
      ma = model_step(ma, mode_a, pause_a, int'(sel_a), 64'(in_a), 4, 4, 1, 16'(mask_a));
      mb = model_step(mb, mode_b, pause_b, int'(sel_b), 64'(in_b), 3, 1, 4, 16'(mask_b));
      check($sformatf("rnd%0d_a_out", n), out_a, ma.out);
      check($sformatf("rnd%0d_a_cur", n), cur_a, ma.ch);
      check($sformatf("rnd%0d_a_wrap", n), wrap_a, ma.wrap);
      check($sformatf("rnd%0d_a_err", n), err_a, ma.err);
      check($sformatf("rnd%0d_b_out", n), out_b, mb.out);
      check($sformatf("rnd%0d_b_cur", n), cur_b, mb.ch);
      check($sformatf("rnd%0d_b_wrap", n), wrap_b, mb.wrap);
      check($sformatf("rnd%0d_b_err", n), err_b, mb.err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire
